vec_cache_wr_resp_router: RTL
=============================

# vec_cache_wr_resp_router

Parametrised write-response router between the cache write-response sources (banks/channels) and the write-back requestor masters. Each input response carries its destination master ID in a configurable payload field. Every output has a round-robin arbiter and an output FIFO, so inputs see per-input ready backpressure and multiple inputs can target the same master without loss. Responses whose master ID is out of range are dropped and counted.

## Interface
- IN_NUM, 8: number of response sources.
- OUT_NUM, 4: number of masters (WB_REQ_NUM); must be ≥2.
- PLD_WIDTH, 32: response payload width.
- MID_LSB, 0: LSB of the master-ID field within the payload.
- MID_W, $clog2(OUT_NUM)+1: master-ID field width. The extra bit allows out-of-range detection.
- FIFO_DEPTH, 4: entries per output FIFO; must be a power of two and ≥2.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_vld  in  IN_NUM  response valid per source.
- in_rdy  out  IN_NUM  response accepted this cycle when in_vld & in_rdy.
- in_pld  in  IN_NUM×PLD_WIDTH  payload per source.
- out_vld  out  OUT_NUM  FIFO head valid per master.
- out_rdy  in  OUT_NUM  master consumes the head.
- out_pld  out  OUT_NUM×PLD_WIDTH  FIFO head payload.
- err_vld  out  1  pulse: at least one out-of-range response was dropped this cycle.
- err_cnt  out  16  saturating count of dropped responses.

## Operation
- Decode: dest[i] = in_pld[i][MID_LSB +: MID_W]. The response is legal if dest[i] < OUT_NUM.
- Illegal response: in_rdy[i] = 1 unconditionally. The response is consumed and discarded, and it never reaches any FIFO.
- err_cnt adds the popcount of illegal handshakes in that cycle and saturates at 16'hFFFF.
- err_vld is registered: it is 1 in the cycle after any illegal handshake.
- Arbitration, per output o:
  - Requesters are the legal inputs with in_vld and dest = o.
  - Round-robin grants exactly one requester per cycle, and only when FIFO o is not full.
  - The pointer ptr[o] marks the highest-priority input. After a grant to input i, ptr[o] becomes (i+1) mod IN_NUM.
  - With no grant, ptr[o] holds.
- in_rdy[i] for a legal input is 1 only when input i holds the grant of FIFO dest[i]. in_rdy is combinational from in_vld, in_pld, FIFO full and ptr.
- FIFO o:
  - Push when a grant is made.
  - Pop when out_vld[o] & out_rdy[o].
  - out_vld[o] = !empty; out_pld[o] = head entry.
  - FIFO ordering is in grant order. There is no ordering guarantee across different outputs.
- Full: full is computed from the current count. A pop in the same cycle does not free space for a push that cycle (no bypass).
- Simultaneous push and pop on a non-full, non-empty FIFO: count is unchanged, and both take effect.
- Pointers wrap modulo FIFO_DEPTH. The count is $clog2(FIFO_DEPTH)+1 bits wide.

## Timing
- Reset values:
  - All FIFOs empty, so out_vld = 0.
  - out_pld = 0.
  - ptr[o] = 0, so input 0 has the highest priority.
  - err_vld = 0 and err_cnt = 0.
  - in_rdy reflects the post-reset state: it is 1 for illegal requests and for legal requests that win arbitration.
- Latency: a handshake in cycle N makes out_vld high in cycle N+1 if the FIFO was empty. Otherwise the response waits behind earlier entries.
- Throughput: one response per output per cycle. Aggregate throughput is up to min(IN_NUM, OUT_NUM) per cycle.
- A source must hold in_vld and in_pld stable until in_rdy. The block does not depend on this for correctness, but arbitration fairness assumes it.
- Reset asserted mid-operation discards all FIFO contents, pointers and the error count on the next edge.

## Test plan
- Single path: input 3 sends ID=2, payload 0xA5 in cycle 0 with out_rdy = 1.
  - Required: in_rdy[3] = 1 in cycle 0.
  - Required: out_vld[2] = 1 with out_pld 0xA5 in cycle 1 only.
- Contention: inputs 0, 1 and 5 all hold ID=1 continuously with out_rdy[1] = 1.
  - Required grant order: 0, 1, 5, 0, 1, 5.
  - Required: the out_pld[1] sequence matches, one entry per cycle.
- Backpressure: out_rdy[0] = 0, and input 2 streams 6 responses to ID=0 (FIFO_DEPTH = 4).
  - Required: exactly 4 accepted, then in_rdy[2] = 0.
  - Raise out_rdy: required in-order drain of all 6, with the 5th accepted one cycle after the first pop.
- Full with simultaneous pop: FIFO at 4 entries, out_rdy = 1 and in_vld = 1 in the same cycle.
  - Required: the pop occurs, the push is refused that cycle, and the push is accepted the next cycle.
- Illegal ID: with OUT_NUM = 4, inputs 4 and 6 send ID=5 in the same cycle.
  - Required: both in_rdy = 1, no out_vld, err_vld = 1 the next cycle, err_cnt = 2.
  - Preload err_cnt near the limit: required saturation at 0xFFFF.
- Reset mid-traffic: assert rst while FIFOs are partially full.
  - Required: out_vld = 0, err_cnt = 0 and ptr = 0 on the next cycle.
  - Required: the first contention after reset grants input 0.

Source files
------------

// File: rtl/vec_cache_wr_resp_router.sv
// Routes cache write responses from IN_NUM sources to OUT_NUM masters by a master-ID payload field.
// Each master has a round-robin arbiter and a FIFO; out-of-range IDs are dropped and counted.
module vec_cache_wr_resp_router #(
    parameter int IN_NUM     = 8,
    parameter int OUT_NUM    = 4,
    parameter int PLD_WIDTH  = 32,
    parameter int MID_LSB    = 0,
    parameter int MID_W      = $clog2(OUT_NUM) + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [IN_NUM-1:0]                   in_vld,
    output logic [IN_NUM-1:0]                   in_rdy,
    input  logic [IN_NUM-1:0][PLD_WIDTH-1:0]    in_pld,
    output logic [OUT_NUM-1:0]                  out_vld,
    input  logic [OUT_NUM-1:0]                  out_rdy,
    output logic [OUT_NUM-1:0][PLD_WIDTH-1:0]   out_pld,
    output logic                                err_vld,
    output logic [15:0]                         err_cnt
);

    localparam int IN_W = (IN_NUM > 1) ? $clog2(IN_NUM) : 1;
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CW   = AW + 1;
    localparam int PC_W = $clog2(IN_NUM + 1);

    logic [IN_NUM-1:0][MID_W-1:0]     dest;
    logic [IN_NUM-1:0]                legal;

    logic [OUT_NUM-1:0][IN_W-1:0]     ptr_q, ptr_d;
    logic [OUT_NUM-1:0][IN_W-1:0]     gnt_idx;
    logic [OUT_NUM-1:0][PLD_WIDTH-1:0] push_pld;
    logic [OUT_NUM-1:0]               push, pop, full;

    logic [OUT_NUM-1:0][AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OUT_NUM-1:0][CW-1:0]       cnt_q, cnt_d;
    logic [PLD_WIDTH-1:0]             mem_q [OUT_NUM][FIFO_DEPTH];

    logic [PC_W-1:0]                  ill_cnt;
    logic [16:0]                      err_sum;
    logic [15:0]                      err_cnt_q, err_cnt_d;
    logic                             err_vld_q, err_vld_d;

    // Index of the k-th candidate counting up from base, wrapping at IN_NUM.
    function automatic logic [IN_W-1:0] rr_idx(input logic [IN_W-1:0] base, input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= IN_NUM) sum -= IN_NUM;
        return IN_W'(sum);
    endfunction

    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            dest[i]  = in_pld[i][MID_LSB +: MID_W];
            legal[i] = (32'(dest[i]) < 32'(OUT_NUM));
        end
    end

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        logic [IN_W-1:0] idx;
        idx      = '0;
        push     = '0;
        gnt_idx  = '0;
        push_pld = '0;
        full     = '0;
        ptr_d    = ptr_q;
        for (int o = 0; o < OUT_NUM; o++) begin
            // Full comes from the registered count only: a same-cycle pop does not make room.
            full[o] = (cnt_q[o] == CW'(FIFO_DEPTH));
            for (int k = 0; k < IN_NUM; k++) begin
                idx = rr_idx(ptr_q[o], k);
                if (!push[o] && !full[o] && in_vld[idx] && legal[idx] &&
                    (dest[idx] == MID_W'(o))) begin
                    push[o]    = 1'b1;
                    gnt_idx[o] = idx;
                end
            end
            push_pld[o] = in_pld[gnt_idx[o]];
            if (push[o]) ptr_d[o] = rr_idx(gnt_idx[o], 1);
        end
    end

    // Illegal responses are always accepted; legal ones only with the grant of their output.
    always_comb begin
        for (int i = 0; i < IN_NUM; i++) begin
            in_rdy[i] = !legal[i];
            for (int o = 0; o < OUT_NUM; o++) begin
                if (push[o] && (gnt_idx[o] == IN_W'(i))) in_rdy[i] = 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        out_vld  = '0;
        out_pld  = '0;
        pop      = '0;
        for (int o = 0; o < OUT_NUM; o++) begin
            out_vld[o] = (cnt_q[o] != '0);
            out_pld[o] = out_vld[o] ? mem_q[o][rd_ptr_q[o]] : '0;
            pop[o]     = out_vld[o] & out_rdy[o];
            if (push[o]) wr_ptr_d[o] = wr_ptr_q[o] + AW'(1);
            if (pop[o])  rd_ptr_d[o] = rd_ptr_q[o] + AW'(1);
            case ({push[o], pop[o]})
                2'b10:   cnt_d[o] = cnt_q[o] + CW'(1);
                2'b01:   cnt_d[o] = cnt_q[o] - CW'(1);
                default: cnt_d[o] = cnt_q[o];
            endcase
        end
    end

    always_comb begin
        ill_cnt = '0;
        for (int i = 0; i < IN_NUM; i++) begin
            ill_cnt = ill_cnt + PC_W'(in_vld[i] & ~legal[i]);
        end
        err_sum   = {1'b0, err_cnt_q} + 17'(ill_cnt);
        err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
        err_vld_d = (ill_cnt != '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            err_cnt_q <= '0;
            err_vld_q <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            err_cnt_q <= err_cnt_d;
            err_vld_q <= err_vld_d;
        end
    end

    // NOTE: the storage array is not reset; out_pld is masked while empty so stale entries never show.
    always_ff @(posedge clk) begin
        for (int o = 0; o < OUT_NUM; o++) begin
            if (push[o]) mem_q[o][wr_ptr_q[o]] <= push_pld[o];
        end
    end

    assign err_cnt = err_cnt_q;
    assign err_vld = err_vld_q;

endmodule
